// File: rtl/control_unit_mc.sv
// rtl/control_unit_mc.sv - multi-cycle control unit: fetch/decode/execute/memory/writeback sequencer
module control_unit_mc #(
    parameter int ALU_CTRL_W = 3,
    parameter int IMM_SRC_W  = 2,
    parameter int FLAG_W     = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            tipo,
    input  logic [1:0]            op,
    input  logic                  Inm,
    input  logic [FLAG_W-1:0]     alu_flags,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  AdrSrc,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  RegWrite,
    output logic                  ALUSrc,
    output logic                  MemWrite,
    output logic                  ResultSrc,
    output logic                  Branch,
    output logic [IMM_SRC_W-1:0]  ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [FLAG_W-1:0]     flags_q,
    output logic                  illegal,
    output logic                  mem_timeout,
    output logic [3:0]            state_o
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWR  = 4'd6,
        S_WB     = 4'd7,
        S_BRANCH = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_ARITH, C_CMP, C_LDR, C_STR, C_BR, C_ILL
    } cls_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t          state;
    cls_t            cls_q;
    cls_t            cls_d;
    logic [1:0]      op_q;
    logic [CNT_W-1:0] wait_cnt;
    logic            timed_out;
    logic            mem_phase;
    logic            req;
    logic            done;
    logic            taken;
    logic [2:0]      alu3;
    logic [1:0]      imm2;

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT));
    assign mem_phase = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // A timed-out request is withdrawn for the cycle that returns to FETCH.
    assign req       = mem_phase && !timed_out;
    assign done      = req && mem_ready;
    assign state_o   = state;

    always_comb begin
        cls_d = C_ILL;
        unique case (tipo)
            2'b00:   cls_d = C_ARITH;
            2'b01:   cls_d = (op == 2'b01) ? C_LDR : (op == 2'b10) ? C_STR : C_ILL;
            2'b10:   cls_d = (op == 2'b10) ? C_CMP : C_BR;
            default: cls_d = C_ILL;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        unique case (op_q)
            2'b00:   taken = 1'b1;
            2'b01:   taken = flags_q[FLAG_W-2];
            2'b11:   taken = !flags_q[FLAG_W-2];
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cls_q       <= C_ARITH;
            op_q        <= 2'b00;
            wait_cnt    <= '0;
            flags_q     <= '0;
            illegal     <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            wait_cnt <= (req && !mem_ready) ? wait_cnt + 1'b1 : '0;
            unique case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (timed_out) begin
                        mem_timeout <= 1'b1;
                        state       <= S_FETCH;
                    end else if (mem_ready) begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    cls_q <= cls_d;
                    op_q  <= op;
                    unique case (cls_d)
                        C_ARITH, C_CMP: state <= S_EXEC;
                        C_LDR, C_STR:   state <= S_MEMADR;
                        C_BR:           state <= S_BRANCH;
                        default: begin
                            illegal <= 1'b1;
                            state   <= S_FETCH;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (cls_q == C_CMP) begin
                        flags_q <= alu_flags;
                        state   <= S_FETCH;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEMADR: state <= (cls_q == C_LDR) ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (timed_out) begin
                        mem_timeout <= 1'b1;
                        state       <= S_FETCH;
                    end else if (mem_ready) begin
                        state <= S_WB;
                    end
                end
                S_MEMWR: begin
                    if (timed_out) begin
                        mem_timeout <= 1'b1;
                        state       <= S_FETCH;
                    end else if (mem_ready) begin
                        state <= S_FETCH;
                    end
                end
                S_WB:     state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrc    = 1'b0;
        MemWrite  = 1'b0;
        ResultSrc = 1'b0;
        Branch    = 1'b0;
        imm2      = 2'b00;
        alu3      = 3'b000;
        unique case (state)
            S_FETCH: begin
                mem_req = req;
                IRWrite = done;
                PCWrite = done;
            end
            S_EXEC: begin
                alu3   = (cls_q == C_CMP) ? 3'b001 : {1'b0, op_q};
                ALUSrc = Inm;
            end
            S_WB: begin
                RegWrite  = 1'b1;
                ResultSrc = (cls_q == C_LDR);
            end
            S_MEMADR: begin
                ALUSrc = 1'b1;
                imm2   = 2'b01;
            end
            S_MEMRD: begin
                mem_req = req;
                AdrSrc  = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = req;
                mem_we   = req;
                MemWrite = req;
                AdrSrc   = 1'b1;
            end
            S_BRANCH: begin
                Branch  = 1'b1;
                imm2    = 2'b10;
                ALUSrc  = 1'b1;
                PCWrite = taken;
            end
            default: ;
        endcase
    end

    assign ImmSrc     = IMM_SRC_W'(imm2);
    assign ALUControl = ALU_CTRL_W'(alu3);
endmodule

// File: tb/tb_control_unit_mc.sv
// tb/tb_control_unit_mc.sv - scoreboard bench for control_unit_mc
module tb_control_unit_mc;
    localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_EXEC = 4'd3,
                           ST_MEMADR = 4'd4, ST_MEMRD = 4'd5, ST_MEMWR = 4'd6, ST_WB = 4'd7,
                           ST_BRANCH = 4'd8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] tipo = 2'b00, op = 2'b00;
    logic       Inm = 1'b0;
    logic [3:0] alu_flags = 4'b0000;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrc, MemWrite, ResultSrc, Branch;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] flags_q;
    logic       illegal, mem_timeout;
    logic [3:0] state_o;

    control_unit_mc dut (
        .clk(clk), .rst_n(rst_n), .tipo(tipo), .op(op), .Inm(Inm), .alu_flags(alu_flags),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .MemWrite(MemWrite), .ResultSrc(ResultSrc), .Branch(Branch), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .flags_q(flags_q), .illegal(illegal),
        .mem_timeout(mem_timeout), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // {state, mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ImmSrc, ALUControl}
    logic [18:0] obs;
    assign obs = {state_o, mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrc,
                  MemWrite, ResultSrc, Branch, ImmSrc, ALUControl};

    typedef struct {
        logic        rdy;
        logic [18:0] exp;
    } item_t;

    item_t q[$];
    int    n_chk = 0;
    int    n_pass = 0;
    string cur_tag = "";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic push(input logic rdy, input logic [3:0] st, input logic [9:0] ctl,
                        input logic [1:0] imm, input logic [2:0] alu);
        item_t it;
        it.rdy = rdy;
        it.exp = {st, ctl, imm, alu};
        q.push_back(it);
    endtask

    // Entered and left at posedge+1; one queue item per clock cycle.
    task automatic run();
        int idx = 0;
        while (q.size() > 0) begin
            item_t it = q.pop_front();
            mem_ready = it.rdy;
            #1;
            check($sformatf("%s.c%0d", cur_tag, idx), 32'(obs), 32'(it.exp));
            idx++;
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic fetch(input int waits);
        for (int i = 0; i < waits; i++) push(1'b0, ST_FETCH, 10'b1000000000, 2'b00, 3'b000);
        push(1'b1, ST_FETCH, 10'b1001100000, 2'b00, 3'b000);
        push(1'b0, ST_DECODE, 10'b0, 2'b00, 3'b000);
    endtask

    task automatic do_arith(input string tag, input logic [1:0] o, input logic inm);
        cur_tag = tag; tipo = 2'b00; op = o; Inm = inm;
        fetch(0);
        push(1'b0, ST_EXEC, {6'b0, inm, 3'b0}, 2'b00, {1'b0, o});
        push(1'b0, ST_WB, 10'b0000010000, 2'b00, 3'b000);
        run();
    endtask

    task automatic do_ldr(input string tag, input int waits);
        cur_tag = tag; tipo = 2'b01; op = 2'b01; Inm = 1'b0;
        fetch(0);
        push(1'b0, ST_MEMADR, 10'b0000001000, 2'b01, 3'b000);
        for (int i = 0; i < waits; i++) push(1'b0, ST_MEMRD, 10'b1010000000, 2'b00, 3'b000);
        push(1'b1, ST_MEMRD, 10'b1010000000, 2'b00, 3'b000);
        push(1'b0, ST_WB, 10'b0000010010, 2'b00, 3'b000);
        run();
    endtask

    task automatic do_cmp(input string tag, input logic [3:0] f);
        cur_tag = tag; tipo = 2'b10; op = 2'b10; Inm = 1'b0; alu_flags = f;
        fetch(0);
        push(1'b0, ST_EXEC, 10'b0, 2'b00, 3'b001);
        run();
        alu_flags = 4'b1011;
        check({tag, ".flags"}, 32'(flags_q), 32'(f));
    endtask

    task automatic do_br(input string tag, input logic [1:0] o, input logic tk);
        cur_tag = tag; tipo = 2'b10; op = o; Inm = 1'b0;
        fetch(0);
        push(1'b0, ST_BRANCH, {4'b0, tk, 1'b0, 1'b1, 2'b00, 1'b1}, 2'b10, 3'b000);
        run();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst.outs", 32'(obs), 32'(0));
        check("rst.sticky", 32'({flags_q, illegal, mem_timeout}), 32'(0));
        rst_n = 1'b1;
        alu_flags = 4'b1111;

        cur_tag = "idle";
        push(1'b0, ST_IDLE, 10'b0, 2'b00, 3'b000);
        run();
        do_arith("add", 2'b00, 1'b0);
        check("arith.noflags", 32'(flags_q), 32'(0));
        do_arith("subi", 2'b01, 1'b1);
        do_arith("and", 2'b10, 1'b0);
        do_arith("orri", 2'b11, 1'b1);
        check("arith.noflags2", 32'(flags_q), 32'(0));

        do_ldr("ldr0", 0);
        do_ldr("ldr3", 3);

        cur_tag = "str"; tipo = 2'b01; op = 2'b10;
        fetch(0);
        push(1'b0, ST_MEMADR, 10'b0000001000, 2'b01, 3'b000);
        push(1'b1, ST_MEMWR, 10'b1110000100, 2'b00, 3'b000);
        push(1'b0, ST_FETCH, 10'b1000000000, 2'b00, 3'b000);
        run();

        do_cmp("cmp_z", 4'b0100);
        do_br("beq_t", 2'b01, 1'b1);
        do_br("bne_n", 2'b11, 1'b0);
        do_arith("add_mid", 2'b00, 1'b0);
        check("flags.hold", 32'(flags_q), 32'(4'b0100));
        do_cmp("cmp_nz", 4'b0000);
        do_br("beq_n", 2'b01, 1'b0);
        do_br("bne_t", 2'b11, 1'b1);
        do_br("b", 2'b00, 1'b1);

        cur_tag = "ill"; tipo = 2'b11; op = 2'b00;
        fetch(0);
        run();
        check("ill.set", 32'(illegal), 32'(1));
        do_arith("after_ill", 2'b00, 1'b0);
        check("ill.sticky", 32'(illegal), 32'(1));

        cur_tag = "tmo"; tipo = 2'b00; op = 2'b01;
        for (int i = 0; i < 16; i++) push(1'b0, ST_FETCH, 10'b1000000000, 2'b00, 3'b000);
        push(1'b1, ST_FETCH, 10'b0, 2'b00, 3'b000);
        run();
        check("tmo.set", 32'(mem_timeout), 32'(1));
        do_arith("retry", 2'b01, 1'b0);
        check("tmo.sticky", 32'(mem_timeout), 32'(1));

        cur_tag = "strw"; tipo = 2'b01; op = 2'b10;
        fetch(0);
        push(1'b0, ST_MEMADR, 10'b0000001000, 2'b01, 3'b000);
        push(1'b0, ST_MEMWR, 10'b1110000100, 2'b00, 3'b000);
        push(1'b0, ST_MEMWR, 10'b1110000100, 2'b00, 3'b000);
        run();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.outs", 32'(obs), 32'(0));
        check("arst.sticky", 32'({flags_q, illegal, mem_timeout}), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("arst.idle", 32'(state_o), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        check("arst.fetch", 32'(state_o), 32'(ST_FETCH));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/control_unit_mc.md
# control_unit_mc

Multi-cycle successor to the combinational processor control unit. It decodes the same `tipo`/`op`/`Inm` instruction fields, but sequences each instruction through fetch, decode, execute, memory and writeback states. It handshakes with a wait-state memory, holds the condition flags internally, and resolves conditional branches. It sits between the instruction register and the datapath muxes, ALU, register file and memory port.

## Interface
- `ALU_CTRL_W`, 3: width of `ALUControl`. Must be ≥3; bits above [2:0] are driven 0.
- `IMM_SRC_W`, 2: width of `ImmSrc`. Must be ≥2; upper bits are 0.
- `FLAG_W`, 4: flag vector width, ordered {N,Z,C,V} from the MSB down. Z is bit `FLAG_W-2`.
- `TIMEOUT`, 16: maximum number of cycles `mem_req` may wait for `mem_ready`. Must be ≥2.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tipo` in 2, `op` in 2, `Inm` in 1: instruction fields from the IR. Valid from DECODE until the instruction ends.
- `alu_flags` in `FLAG_W`: ALU flag outputs, combinational from the current ALU operands.
- `mem_ready` in 1: the memory has accepted or completed the current request. Ignored while `mem_req`=0.
- `mem_req` out 1, `mem_we` out 1: memory request and write enable.
- `AdrSrc` out 1: memory address select, 0=PC, 1=ALU result.
- `IRWrite` out 1, `PCWrite` out 1: instruction-register load and PC load.
- `RegWrite`, `ALUSrc`, `MemWrite`, `ResultSrc`, `Branch` out 1 each: same meaning as in the combinational unit.
- `ImmSrc` out `IMM_SRC_W`: immediate format select.
- `ALUControl` out `ALU_CTRL_W`: ALU operation select.
- `flags_q` out `FLAG_W`: stored condition flags.
- `illegal` out 1: sticky; set on `tipo`=11.
- `mem_timeout` out 1: sticky; set when a memory request exceeds `TIMEOUT` cycles.
- `state_o` out 4: current state encoding, for debug.

## Operation
- Decode map, `ALUControl` values:
  - `tipo`=00 (arithmetic): `op` 00 ADD (000), 01 SUB (001), 10 AND (010), 11 ORR (011).
  - `tipo`=01 (data transfer): `op` 01 LDR, 10 STR. `op` 00/11 are illegal.
  - `tipo`=10 (flow control): `op` 00 B, 01 BEQ, 10 CMP, 11 BNE.
  - `tipo`=11: illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEMADR, MEMRD, MEMWR, WB, BRANCH.
- All outputs are Moore outputs of the state plus the latched decode. Any signal not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH unconditionally.
- FETCH: `mem_req`=1, `AdrSrc`=0. Holds until `mem_ready`=1. In the `mem_ready` cycle, `IRWrite`=1 and `PCWrite`=1 (PC+4), then goes to DECODE.
- DECODE: latches the decoded op class and ALU op into internal registers. Next state:
  - arithmetic or CMP → EXEC;
  - LDR/STR → MEMADR;
  - B/BEQ/BNE → BRANCH;
  - illegal → set `illegal`, go to FETCH.
- EXEC:
  - `ALUControl`=latched op; `ALUSrc`=`Inm`; `ImmSrc`=00.
  - Arithmetic goes to WB.
  - CMP forces SUB, loads `flags_q` ← `alu_flags` at the end of the cycle, then goes to FETCH.
- WB: `RegWrite`=1. `ResultSrc`=1 after LDR, 0 after arithmetic. Goes to FETCH.
- MEMADR: `ALUSrc`=1, `ImmSrc`=01, `ALUControl`=ADD. Goes to MEMRD for LDR, MEMWR for STR.
- MEMRD: `mem_req`=1, `AdrSrc`=1. Goes to WB on `mem_ready`.
- MEMWR: `mem_req`=1, `mem_we`=1, `MemWrite`=1, `AdrSrc`=1. Goes to FETCH on `mem_ready`.
- BRANCH:
  - `Branch`=1, `ImmSrc`=10, `ALUSrc`=1, `ALUControl`=ADD.
  - taken = B, or BEQ with Z=1, or BNE with Z=0, using `flags_q`.
  - `PCWrite`=taken. Goes to FETCH.
- Flags change only in EXEC for CMP. Arithmetic instructions do not update the flags.
- Wait counter:
  - counts cycles with `mem_req`=1 and `mem_ready`=0; cleared on `mem_ready` or on any state change.
  - When it reaches `TIMEOUT`, `mem_timeout` is set and the state goes to FETCH; `mem_req` is 0 for that transition cycle.
  - A timed-out store performs no write. A timed-out load performs no `RegWrite`.

## Timing
- Reset values:
  - state=IDLE;
  - `flags_q`=0, `illegal`=0, `mem_timeout`=0, wait counter=0;
  - all control outputs 0.
- Reset assertion mid-instruction forces IDLE immediately, asynchronously. Outputs drop to 0 without waiting for `mem_ready`.
- Latency with zero-wait memory (`mem_ready` high in the first request cycle), FETCH to next FETCH:
  - arithmetic: 4 cycles;
  - LDR: 5 cycles;
  - STR: 4 cycles;
  - CMP: 3 cycles;
  - branch: 3 cycles;
  - illegal: 2 cycles.
- Each wait cycle adds 1 cycle.
- `mem_req` stays high and stable, together with `mem_we` and `AdrSrc`, until the `mem_ready` cycle. It drops in the following cycle unless the next state also requests.
- Back-to-back: a CMP's flags are visible to an immediately following BEQ/BNE, because `flags_q` is written before the branch reaches BRANCH.
- `illegal` and `mem_timeout` clear only on reset.

## Test plan
- Reset, then ADD reg (tipo=00, op=00, Inm=0), zero-wait memory → `state_o` passes IDLE, FETCH, DECODE, EXEC, WB. In WB: `RegWrite`=1, `ResultSrc`=0, `ALUControl`=000. In EXEC: `ALUSrc`=0.
- LDR (01/01) with 3 wait cycles on the data read → MEMRD holds `mem_req`=1, `AdrSrc`=1 for 4 cycles. Then WB with `ResultSrc`=1 and `RegWrite`=1. Total 8 cycles.
- STR (01/10) → MEMWR with `mem_we`=`MemWrite`=1 for exactly 1 cycle. `RegWrite` stays 0 throughout.
- CMP (10/10) with `alu_flags`=0100, then BEQ → `flags_q`=0100 and `PCWrite`=1 in BRANCH. Repeat with `alu_flags`=0000 → BEQ gives `PCWrite`=0, BNE gives `PCWrite`=1.
- tipo=11 → `illegal`=1 after DECODE, back in FETCH within 2 cycles, `illegal` stays set. Separately, hold `mem_ready`=0 in FETCH for 16 cycles → `mem_timeout`=1, then FETCH is retried.
- Assert `rst_n`=0 during a MEMWR wait → all outputs 0 immediately. State is IDLE on release, and `flags_q`/`illegal`/`mem_timeout` are 0.
